// File: rtl/eth_pkt_pkg.sv
// Shared constants for the Ethernet TX path: arbiter FSM states,
// fixed channel assignments of the packet generators, and packet-type codes.
// No logic; imported by the arbiter and its picker.
package eth_pkt_pkg;

    // Arbiter FSM states (kept as plain constants for legacy tools)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Channel index of each packet generator on the arbiter
    localparam int CH_ARP  = 0;
    localparam int CH_PING = 1;
    localparam int CH_UDP  = 2;

    // Packet-type codes carried alongside the granted stream
    typedef enum logic [2:0] {
        PT_NONE       = 3'd0,
        PT_ARP_REPLY  = 3'd1,
        PT_ICMP_REPLY = 3'd2,
        PT_UDP        = 3'd3
    } pt_t;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Bundle of arbiter request/grant signals between generators and the arbiter.
// master: arbiter side (drives o_*), slave: generator/requester side (drives i_*).
// Ports: i_rr_mode, i_req, i_evt, i_ready, i_timeout in; o_grant, o_grant_idx, o_busy, o_start, o_timeout out.
interface eth_tx_arbiter_if #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH),
    parameter int TO_W = 16
);
    logic            i_rr_mode;
    logic [N_CH-1:0] i_req;
    logic [N_CH-1:0] i_evt;
    logic [N_CH-1:0] i_ready;
    logic [TO_W-1:0] i_timeout;
    logic [N_CH-1:0] o_grant;
    logic [CH_W-1:0] o_grant_idx;
    logic            o_busy;
    logic [N_CH-1:0] o_start;
    logic            o_timeout;

    modport master (
        input  i_rr_mode, i_req, i_evt, i_ready, i_timeout,
        output o_grant, o_grant_idx, o_busy, o_start, o_timeout
    );

    modport slave (
        output i_rr_mode, i_req, i_evt, i_ready, i_timeout,
        input  o_grant, o_grant_idx, o_busy, o_start, o_timeout
    );
endinterface

// File: rtl/eth_arb_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin from ptr+1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; eligibility already folds in generator readiness.
// Ports: eligible/ptr/rr_mode in; win_oh (one-hot), win_idx, win_vld out.
module eth_arb_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] eligible,
    input  logic [CH_W-1:0] ptr,
    input  logic            rr_mode,
    output logic [N_CH-1:0] win_oh,
    output logic [CH_W-1:0] win_idx,
    output logic            win_vld
);

    always_comb begin
        int              j;
        logic [CH_W-1:0] cand;
        j       = 0;
        cand    = '0;
        win_idx = '0;
        win_vld = 1'b0;
        // Walk candidates in priority order; first eligible one wins.
        // In round-robin mode the walk starts just after the last winner.
        for (int k = 0; k < N_CH; k++) begin
            if (rr_mode) begin
                j = (int'(ptr) + 1 + k) % N_CH;
            end else begin
                j = k;
            end
            cand = CH_W'(j);
            if (!win_vld && eligible[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_oh = win_vld ? (N_CH'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// TX source arbiter: grants one generator the MAC stream until its ready rises again.
// Latency: eligible in t -> grant/start in t+1; ready rise in t -> release in t+1.
// Backpressure: a generator is only eligible while its i_ready is high; grant held until done.
// Ports: clk, rst_n (async, active-low) plus eth_tx_arbiter_if.master bus.
// Optional macro ETH_TX_ARB_TIMEOUT_EN adds a grant-length watchdog (i_timeout, o_timeout).
module eth_tx_arbiter
    import eth_pkt_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH),
    parameter int TO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    eth_tx_arbiter_if.master bus
);

    logic [0:0]      state;
    logic [N_CH-1:0] ready_q;
    logic [N_CH-1:0] evt_q;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] start;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] rr_ptr;

    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] win_oh;
    logic [CH_W-1:0] win_idx;
    logic            win_vld;
    logic            done_edge;
    logic            timeout_hit;
    logic            release_now;

    assign eligible = (bus.i_req | pending) & bus.i_ready;

    eth_arb_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .rr_mode  (bus.i_rr_mode),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    // Only the owner's ready edge ends a grant; other channels are ignored.
    assign done_edge   = bus.i_ready[grant_idx] & ~ready_q[grant_idx];
    assign release_now = done_edge | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= CH_W'(N_CH - 1);
            start     <= '0;
            pending   <= '0;
            ready_q   <= '0;
            evt_q     <= '0;
        end else begin
            ready_q <= bus.i_ready;
            evt_q   <= bus.i_evt;
            // A new event edge beats the clear from o_start so it is not lost.
            pending <= (pending & ~start) | (bus.i_evt & ~evt_q);
            start   <= '0;
            if (state == ST_IDLE) begin
                if (win_vld) begin
                    state     <= ST_GRANT;
                    grant     <= win_oh;
                    grant_idx <= win_idx;
                    rr_ptr    <= win_idx;
                    start     <= win_oh;
                end
            end else if (release_now) begin
                state <= ST_IDLE;
                grant <= '0;
            end
        end
    end

`ifdef ETH_TX_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_inc;
    logic            to_pulse;

    assign to_cnt_inc  = to_cnt + TO_W'(1);
    // to_cnt_inc counts the current grant cycle, so release follows exactly
    // i_timeout grant cycles.
    assign timeout_hit = (state == ST_GRANT) && (bus.i_timeout != '0) &&
                         (to_cnt_inc == bus.i_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else begin
            // A genuine done in the same cycle is a normal release.
            to_pulse <= timeout_hit & ~done_edge;
            if (state == ST_GRANT) begin
                to_cnt <= to_cnt_inc;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    assign bus.o_timeout = to_pulse;
`else
    logic [TO_W-1:0] unused_timeout;
    assign unused_timeout = bus.i_timeout;
    assign timeout_hit    = 1'b0;
    assign bus.o_timeout  = 1'b0;
`endif

    assign bus.o_grant     = grant;
    assign bus.o_grant_idx = grant_idx;
    assign bus.o_busy      = |grant;
    assign bus.o_start     = start;

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Parametrised transmit-source arbiter for the Ethernet TX path. It selects one of N_CH packet generators (ARP reply, ping reply, UDP stream, …) to own the MAC transmit stream. It holds that grant until the generator signals completion, and issues one-cycle start/clear pulses to the winner. It supports fixed-priority and round-robin modes and latches edge-type requests such as frame sync.

## Interface
- N_CH, 4: number of requesting channels, 2..16.
- CH_W, $clog2(N_CH): index width.
- TO_W, 16: timeout counter width (used only with timeout feature).

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_rr_mode  in  1  0 = fixed priority (ch0 highest), 1 = round-robin.
- i_req  in  N_CH  level requests (e.g. ARP/ping request flags).
- i_evt  in  N_CH  event requests; rising edge latched into pending bit.
- i_ready  in  N_CH  generator ready; low while sending, rise = done.
- i_timeout  in  TO_W  max grant length in cycles (timeout feature only).
- o_grant  out  N_CH  one-hot current owner; 0 when idle.
- o_grant_idx  out  CH_W  index of owner; holds last owner when idle.
- o_busy  out  1  |o_grant.
- o_start  out  N_CH  one-cycle pulse, first cycle of a grant; also clears the requester's flag.
- o_timeout  out  1  one-cycle pulse on forced release (timeout feature only).

## Operation
- States: IDLE, GRANT. Reset: IDLE, all outputs 0, pending 0, RR pointer = N_CH-1, all edge registers 0.
- Eligible[i] = (i_req[i] | pending[i]) & i_ready[i].
- IDLE: if any eligible, pick the winner, register o_grant/o_grant_idx, pulse o_start[winner], and go to GRANT. Otherwise stay.
- Fixed mode: the lowest eligible index wins.
- RR mode: search starts at pointer+1 mod N_CH. The pointer updates to the winner on every grant, in both modes.
- GRANT: release on a rising edge of i_ready[o_grant_idx], detected against the registered previous value. On release, return to IDLE and o_grant goes 0.
- Ready edges of non-owner channels are ignored.
- pending[i]: set on a rising edge of i_evt[i]; cleared by o_start[i]. Set wins if both happen in the same cycle, so the event is not lost.
- Mode change takes effect at the next IDLE decision. It never preempts an active grant.
- Reset asserted mid-grant: immediate return to reset state. No o_start or o_timeout is emitted.

## Timing
- Request to grant: eligible in cycle t → o_grant and o_start valid in cycle t+1.
- Done to release: i_ready rises in cycle t (previous value 0) → o_grant = 0 in t+1.
- At least one IDLE cycle between consecutive grants. The earliest next o_start is t+2.
- i_evt rising edge in cycle t → pending set in t+1 → earliest grant t+2.
- Owner's i_ready held high throughout GRANT: no release. Without the timeout feature this is a permanent hold.

## Configuration
- ETH_TX_ARB_TIMEOUT_EN defined:
  - A TO_W counter clears on grant and increments each GRANT cycle.
  - When it reaches i_timeout, the arbiter forces release (same cycle behaviour as done) and pulses o_timeout.
  - i_timeout = 0 disables the timeout.
- Not defined: no counter. o_timeout is tied 0 and i_timeout is unused.

## Structure
- Shared package eth_pkt_pkg:
  - IDLE/GRANT state constants.
  - Channel index constants CH_ARP=0, CH_PING=1, CH_UDP=2.
  - PT_* packet-type codes.
- Sub-module eth_arb_pick: combinational picker. Inputs: eligible vector, pointer, mode. Outputs: one-hot winner and index.
- Edge detection is done with registers inside the block.

## Test plan
- N_CH=4, fixed mode, i_req=4'b0110, i_ready=4'hF → o_grant=4'b0010 next cycle and o_start=4'b0010 for one cycle. Drop then raise i_ready[1] → release, then one idle cycle, then ch2 granted.
- RR mode, i_req=4'hF held, each owner completes after 3 cycles → grant order 0,1,2,3,0, with o_start pulsing once per grant.
- i_evt[2] pulsed on the same cycle that o_start[2] fires → pending stays set, and ch2 is granted a second time after release.
- During a ch0 grant, toggle i_ready[3] 0→1 → no release; ch0 keeps the grant until i_ready[0] rises.
- With ETH_TX_ARB_TIMEOUT_EN, i_timeout=10, owner never completes → release after 10 GRANT cycles and o_timeout pulses once. With i_timeout=0 → no release.
- Assert rst_n low mid-grant → o_grant, o_start and pending = 0 asynchronously. After reset the RR pointer is N_CH-1, so ch0 wins first.
